data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/mem_pkg.sv | 39 +++
 rtl/byte_ram.sv | 21 ++
 rtl/data_mem_responder.sv | 128 ++++++++++++
 tb/tb_data_mem_responder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states,
// the latched request record and the load-extension helper.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [5:0]  rd;
    logic [5:0]  rob;
    logic [11:0] pc;
  } req_t;

  // Size 2'b11 falls into the word case.
  function automatic logic [2:0] nbytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: nbytes = 3'd1;
      SZ_HALF: nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] size,
                                         input logic uns);
    case (size)
      SZ_BYTE: extend = uns ? {24'h0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
      SZ_HALF: extend = uns ? {16'h0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

endpackage

// File: rtl/byte_ram.sv
// Single-port byte-wide storage: synchronous write, combinational read, no reset.
module byte_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Serialises LSQ loads/stores into one byte access per cycle against a byte RAM,
// little-endian with wrap-around, and returns an extended completion.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [5:0]            req_rd,
  input  logic [5:0]            req_rob,
  input  logic [11:0]           req_pc,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_wr,
  output logic [31:0]           resp_data,
  output logic [5:0]            resp_rd,
  output logic [5:0]            resp_rob,
  output logic [11:0]           resp_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t                state, state_nxt;
  req_t                  req_q;
  logic [AW-1:0]         base_q;
  logic [1:0]            k;
  logic [31:0]           data_q, data_asm;
  logic [ADDR_WIDTH-1:0] addr_mod;
  logic [AW:0]           addr_sum;
  logic [AW-1:0]         addr;
  logic [7:0]            rdata, wdata;
  logic                  we, last;

  // Base is reduced once at accept; per-byte wrap then needs a single subtract.
  assign addr_mod  = req_addr % ADDR_WIDTH'(DEPTH);
  assign addr_sum  = {1'b0, base_q} + (AW+1)'(k);
  assign addr      = (addr_sum >= (AW+1)'(DEPTH)) ? AW'(addr_sum - (AW+1)'(DEPTH))
                                                  : addr_sum[AW-1:0];
  assign last      = ({1'b0, k} == nbytes(req_q.size) - 3'd1);
  assign wdata     = req_q.wdata[8*k +: 8];
  // Gated by rst so an aborting reset edge does not commit the in-flight byte.
  assign we        = (state == ACCESS) && req_q.wr && rst;
  assign req_ready = (state == IDLE);

  always_comb begin
    data_asm           = data_q;
    data_asm[8*k +: 8] = rdata;
  end

  byte_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid)  state_nxt = ACCESS;
      ACCESS:  if (last)       state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      req_q      <= '0;
      base_q     <= '0;
      k          <= '0;
      data_q     <= '0;
      resp_valid <= 1'b0;
      resp_wr    <= 1'b0;
      resp_data  <= '0;
      resp_rd    <= '0;
      resp_rob   <= '0;
      resp_pc    <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          req_q.wr    <= req_wr;
          req_q.size  <= req_size;
          req_q.uns   <= req_unsigned;
          req_q.wdata <= req_wdata;
          req_q.rd    <= req_rd;
          req_q.rob   <= req_rob;
          req_q.pc    <= req_pc;
          base_q      <= addr_mod[AW-1:0];
          k           <= '0;
          data_q      <= '0;
        end
        ACCESS: begin
          data_q <= data_asm;
          if (last) begin
            k          <= '0;
            resp_valid <= 1'b1;
            resp_wr    <= req_q.wr;
            resp_data  <= req_q.wr ? 32'h0 : extend(data_asm, req_q.size, req_q.uns);
            resp_rd    <= req_q.rd;
            resp_rob   <= req_q.rob;
            resp_pc    <= req_q.pc;
          end else begin
            k <= k + 2'd1;
          end
        end
        RESP: if (resp_ready) resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: stores/loads of all sizes, extension,
// wrap-around, response back-pressure and reset abort, with hand-computed values.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic        req_wr = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [19:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [5:0]  req_rd = '0, req_rob = '0;
  logic [11:0] req_pc = '0;
  logic        resp_valid, resp_ready = 1'b0, resp_wr;
  logic [31:0] resp_data;
  logic [5:0]  resp_rd, resp_rob;
  logic [11:0] resp_pc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(20), .DEPTH(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .req_rob(req_rob), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_wr(resp_wr),
    .resp_data(resp_data), .resp_rd(resp_rd), .resp_rob(resp_rob), .resp_pc(resp_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where resp_valid is seen (or timeout).
  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [19:0] a, input logic [31:0] wd,
                       input logic [5:0] rd, input logic [5:0] rob,
                       input logic [11:0] pc, output int lat);
    int guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    req_valid = 1'b1; req_wr = wr; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd; req_rd = rd; req_rob = rob; req_pc = pc;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 20);
  endtask

  task automatic consume(input string tag);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_idle"}, {30'h0, resp_valid, req_ready}, 32'h1);
  endtask

  task automatic load(input string tag, input logic [1:0] sz, input logic uns,
                      input logic [19:0] a, input int n, input logic [31:0] exp);
    int lat;
    issue(1'b0, sz, uns, a, 32'h0, 6'd3, 6'd7, 12'h123, lat);
    chk({tag, "_lat"}, lat, n + 1);
    chk({tag, "_data"}, resp_data, exp);
    chk({tag, "_wr"}, {31'h0, resp_wr}, 32'h0);
    chk({tag, "_rob"}, {26'h0, resp_rob}, 32'd7);
    consume(tag);
  endtask

  task automatic store(input string tag, input logic [1:0] sz, input logic [19:0] a,
                       input int n, input logic [31:0] wd);
    int lat;
    issue(1'b1, sz, 1'b0, a, wd, 6'd1, 6'd2, 12'h0AB, lat);
    chk({tag, "_lat"}, lat, n + 1);
    chk({tag, "_wr"}, {31'h0, resp_wr}, 32'h1);
    chk({tag, "_data"}, resp_data, 32'h0);
    consume(tag);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_wr", {31'h0, resp_wr}, 32'h0);
    chk("rst_data", resp_data, 32'h0);
    chk("rst_tags", {14'h0, resp_rd, resp_rob, resp_pc}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'h0, req_ready}, 32'h1);

    // Word store/load and sub-word extension
    store("st_w10", 2'b10, 20'h00010, 4, 32'hDEADBEEF);
    load("ld_w10", 2'b10, 1'b0, 20'h00010, 4, 32'hDEADBEEF);
    load("ld_ub10", 2'b00, 1'b1, 20'h00010, 1, 32'h000000EF);
    load("ld_sb13", 2'b00, 1'b0, 20'h00013, 1, 32'hFFFFFFDE);
    load("ld_ub13", 2'b00, 1'b1, 20'h00013, 1, 32'h000000DE);
    load("ld_sh12", 2'b01, 1'b0, 20'h00012, 2, 32'hFFFFDEAD);
    load("ld_uh10", 2'b01, 1'b1, 20'h00010, 2, 32'h0000BEEF);

    // Byte store, positive sign, size 11 as word
    store("st_b11", 2'b00, 20'h00011, 1, 32'hFFFFFF7F);
    load("ld_sb11", 2'b00, 1'b0, 20'h00011, 1, 32'h0000007F);
    load("ld_s3_10", 2'b11, 1'b0, 20'h00010, 4, 32'hDEAD7FEF);

    // Half store touches only two bytes
    store("st_w30", 2'b10, 20'h00030, 4, 32'h00000000);
    store("st_h30", 2'b01, 20'h00030, 2, 32'h9999ABCD);
    load("ld_w30", 2'b10, 1'b0, 20'h00030, 4, 32'h0000ABCD);
    load("ld_sh30", 2'b01, 1'b0, 20'h00030, 2, 32'hFFFFABCD);

    // Wrap-around past DEPTH-1 and ignored upper address bits
    store("st_w3fe", 2'b10, 20'h003FE, 4, 32'h11223344);
    load("ld_w3fe", 2'b10, 1'b0, 20'h003FE, 4, 32'h11223344);
    load("ld_ub000", 2'b00, 1'b1, 20'h00000, 1, 32'h00000022);
    load("ld_ub001", 2'b00, 1'b1, 20'h00001, 1, 32'h00000011);
    load("ld_ub400", 2'b00, 1'b1, 20'h00400, 1, 32'h00000022);
    load("ld_ubfff", 2'b00, 1'b1, 20'hFFFFF, 1, 32'h00000033);
    load("ld_uhfff", 2'b01, 1'b1, 20'hFFFFF, 2, 32'h00002233);

    // Response held under back-pressure
    begin
      int lat;
      issue(1'b0, 2'b10, 1'b0, 20'h00010, 32'h0, 6'd5, 6'd9, 12'h040, lat);
      chk("hold_lat", lat, 5);
      for (int i = 0; i < 3; i++) begin
        chk("hold_valid", {31'h0, resp_valid}, 32'h1);
        chk("hold_ready", {31'h0, req_ready}, 32'h0);
        chk("hold_data", resp_data, 32'hDEAD7FEF);
        chk("hold_tags", {14'h0, resp_rd, resp_rob, resp_pc}, {14'h0, 6'd5, 6'd9, 12'h040});
        @(negedge clk);
      end
      consume("hold");
    end

    // Reset mid-ACCESS after two bytes of a word store
    store("st_w20", 2'b10, 20'h00020, 4, 32'h55667788);
    req_valid = 1'b1; req_wr = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 20'h00020; req_wdata = 32'hAABBCCDD;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_valid0", {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    chk("abort_data", resp_data, 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_novalid", {31'h0, resp_valid}, 32'h0);
    end
    load("ld_w20", 2'b10, 1'b0, 20'h00020, 4, 32'h5566CCDD);
    load("ld_w3fe_kept", 2'b10, 1'b0, 20'h003FE, 4, 32'h11223344);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
